serial_word_receiver: RTL

- Serial-in, parallel-out receiver for the team's LSB-first serial word link (serial data line plus end-of-sequence strobe, one bit per clock).
- Sits at the far end of the link from the shift-out transmitter. Rebuilds each BITS-wide word, checks framing and hands the word to downstream logic over a valid/ready handshake.
- Detects framing errors and overruns and resynchronises on its own.

---
 rtl/serial_word_receiver.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_word_receiver.sv
// ---------------------------------------------------------------------------
// serial_word_receiver
//
// Serial-in, parallel-out receiver for the LSB-first serial word link. Each
// frame is BITS data cycles (eos=0) followed by one cycle that repeats the
// last data bit with eos=1. The receiver rebuilds the word, checks the
// framing, and hands good words downstream over a valid/ready handshake.
// Framing errors raise a one-cycle pulse and the receiver resynchronises
// without outside help.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   clock enable; all state and outputs hold while low
//   sin        in   serial data, LSB first
//   eos        in   end-of-sequence strobe
//   dout       out  last committed word
//   dvalid     out  dout holds a word not yet consumed
//   dready     in   downstream accepts dout on this edge
//   frame_err  out  one enabled cycle pulse after a framing error
//   overrun    out  sticky; a completed word was dropped
//   err_seen   out  sticky; a framing error has occurred since reset
// ---------------------------------------------------------------------------
module serial_word_receiver #(
   parameter int BITS = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            sin,
   input  logic            eos,
   output logic [BITS-1:0] dout,
   output logic            dvalid,
   input  logic            dready,
   output logic            frame_err,
   output logic            overrun,
   output logic            err_seen
);

   localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   localparam logic [1:0] ALIGN = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] HUNT  = 2'd3;

   logic [1:0]      state;
   logic [1:0]      state_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic [BITS-1:0] shreg;
   logic [BITS-1:0] shreg_next;
   logic            commit;
   logic            err;

   always_comb begin
      state_next = state;
      count_next = count;
      shreg_next = shreg;
      commit     = 1'b0;
      err        = 1'b0;
      case (state)
         // First enabled edge after reset: the transmitter is still loading
         // its first word, so the line is ignored.
         ALIGN: begin
            state_next = RECV;
            count_next = '0;
         end
         RECV: begin
            if (eos) begin
               // Early end of frame: drop the partial word and treat the
               // next cycle as bit 0.
               err        = 1'b1;
               count_next = '0;
            end else begin
               for (int i = 0; i < BITS; i++) begin
                  if (count == CW'(i)) shreg_next[i] = sin;
               end
               if (count == LAST) begin
                  state_next = CHECK;
                  count_next = '0;
               end else begin
                  count_next = count + CW'(1);
               end
            end
         end
         // The eos cycle repeats the last data bit; both must agree.
         CHECK: begin
            count_next = '0;
            if (!eos) begin
               err        = 1'b1;
               state_next = HUNT;
            end else if (sin != shreg[BITS-1]) begin
               err        = 1'b1;
               state_next = RECV;
            end else begin
               commit     = 1'b1;
               state_next = RECV;
            end
         end
         // Lost alignment: wait for the end of whatever frame is in flight.
         HUNT: begin
            if (eos) begin
               state_next = RECV;
               count_next = '0;
            end
         end
         default: begin
            state_next = ALIGN;
            count_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ALIGN;
         count     <= '0;
         shreg     <= '0;
         dout      <= '0;
         dvalid    <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         err_seen  <= 1'b0;
      end else if (ena) begin
         state     <= state_next;
         count     <= count_next;
         shreg     <= shreg_next;
         frame_err <= err;
         if (err) err_seen <= 1'b1;
         if (commit) begin
            // A pending word consumed on this same edge frees the slot.
            if (!dvalid || dready) begin
               dout   <= shreg;
               dvalid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (dvalid && dready) begin
            dvalid <= 1'b0;
         end
      end
   end

endmodule
